// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// wait-counter width, bus widths and a byte-lane mask helper.
package data_mem_resp_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_BUSY = 2'd1,
    DMEM_ST_DONE = 2'd2
  } dmem_state_e;

  function automatic logic [DMEM_DATA_W-1:0] dmem_lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/data_mem_resp_dmem_array.sv
// Word-organised RAM: one byte-lane-enabled write port, one asynchronous read port.
module data_mem_resp_dmem_array
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned AddrW = 10
) (
  input  logic                   clk_i,
  input  logic [3:0]             we_i,
  input  logic [AddrW-1:0]       waddr_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  input  logic [AddrW-1:0]       raddr_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  logic [DMEM_DATA_W-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_resp.sv
// CPU data-memory responder with configurable wait states and a stall request.
// Optional DMEM_OOR_ERR_EN adds err_o and blocks accesses above the RAM depth.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             ce_i,
  input  logic                   we_i,
  input  logic [DMEM_ADDR_W-1:0] addr_i,
  input  logic [3:0]             sel_i,
  input  logic [DMEM_DATA_W-1:0] data_i,
  output logic [DMEM_DATA_W-1:0] data_o,
  output logic                   stallreq_o
`ifdef DMEM_OOR_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int unsigned CntInit = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  dmem_state_e            state_q, state_d;
  logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [3:0]             sel_q, sel_d;
  logic [DMEM_DATA_W-1:0] wdat_q, wdat_d;
  logic                   oor_q, oor_d;

  logic                   req;
  logic                   oor_in;
  logic                   cmp_oor;
  logic [ADDR_W-1:0]      idx_in;
  logic [3:0]             mem_we;
  logic [ADDR_W-1:0]      mem_waddr, mem_raddr;
  logic [DMEM_DATA_W-1:0] mem_wdata, mem_rdata;

  assign req    = |ce_i;
  assign idx_in = addr_i[ADDR_W+1:2];

`ifdef DMEM_OOR_ERR_EN
  logic err_q, err_d;
  logic unused_sigs;
  assign oor_in      = |addr_i[DMEM_ADDR_W-1:ADDR_W+2];
  assign unused_sigs = ^addr_i[1:0];
  assign err_d       = err_q | cmp_oor;
  assign err_o       = err_q;
`else
  logic unused_sigs;
  // Upper address bits are dropped so accesses wrap modulo the RAM depth.
  assign oor_in      = 1'b0;
  assign unused_sigs = ^{addr_i[1:0], addr_i[DMEM_ADDR_W-1:ADDR_W+2], cmp_oor};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    oor_d      = oor_q;
    stallreq_o = 1'b0;
    data_o     = '0;
    mem_we     = '0;
    mem_waddr  = idx_in;
    mem_wdata  = data_i;
    mem_raddr  = idx_in;
    cmp_oor    = 1'b0;

    unique case (state_q)
      DMEM_ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            cmp_oor = oor_in;
            if (we_i) begin
              mem_we = oor_in ? 4'b0000 : sel_i;
            end else if (!oor_in) begin
              data_o = mem_rdata & dmem_lane_mask(sel_i);
            end
          end else begin
            stallreq_o = 1'b1;
            we_d       = we_i;
            idx_d      = idx_in;
            sel_d      = sel_i;
            wdat_d     = data_i;
            oor_d      = oor_in;
            cnt_d      = DMEM_CNT_W'(CntInit);
            state_d    = DMEM_ST_BUSY;
          end
        end
      end
      DMEM_ST_BUSY: begin
        stallreq_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = DMEM_ST_DONE;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      DMEM_ST_DONE: begin
        mem_raddr = idx_q;
        mem_waddr = idx_q;
        mem_wdata = wdat_q;
        cmp_oor   = oor_q;
        if (we_q) begin
          mem_we = oor_q ? 4'b0000 : sel_q;
        end else if (!oor_q) begin
          data_o = mem_rdata & dmem_lane_mask(sel_q);
        end
        state_d = DMEM_ST_IDLE;
      end
      default: state_d = DMEM_ST_IDLE;
    endcase

    // A reset edge must never commit a write, including one pending in DONE.
    if (reset) begin
      mem_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMEM_ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      oor_q   <= 1'b0;
`ifdef DMEM_OOR_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      oor_q   <= oor_d;
`ifdef DMEM_OOR_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  data_mem_resp_dmem_array #(
    .AddrW(ADDR_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

endmodule
